// File: rtl/ex_pkg.sv
// Shared definitions for the ID/EX operand-delivery stage.
//  - ALU_* : ALU operation codes carried from decode to the ALU (0 ADD .. 9 SLT).
//  - fwd_sel_t : operand source selected by the forwarding unit.
package ex_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;
  localparam logic [3:0] ALU_SLT = 4'd9;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/ex_fwd_unit.sv
// Forwarding selector for one source operand of the instruction in EX.
// Ports:
//  src_i             source register address held in the ID/EX register
//  exmem_reg_write_i EX/MEM stage will write back
//  exmem_rd_i        EX/MEM destination register
//  memwb_reg_write_i MEM/WB stage will write back
//  memwb_rd_i        MEM/WB destination register
//  sel_o             chosen operand source (EX/MEM beats MEM/WB beats regfile)
module ex_fwd_unit
  import ex_pkg::*;
#(
  parameter int RAW = 5
) (
  input  logic [RAW-1:0] src_i,
  input  logic           exmem_reg_write_i,
  input  logic [RAW-1:0] exmem_rd_i,
  input  logic           memwb_reg_write_i,
  input  logic [RAW-1:0] memwb_rd_i,
  output fwd_sel_t       sel_o
);

  // Register 0 is hard-wired zero, so a write to it is never a producer.
  always_comb begin
    sel_o = FWD_REG;
    if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i)) sel_o = FWD_MEMWB;
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i)) sel_o = FWD_EXMEM;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and ALU operand delivery.
// Captures the decoded instruction from ID, resolves RAW hazards and drives the ALU
// operands, store data and control bits toward the EX/MEM boundary.
// Build option: define EX_FORWARD_EN to enable EX/MEM and MEM/WB bypassing (stall only on
// load-use). Without it operands come straight from the registered regfile data and any
// RAW against EX or EX/MEM stalls ID.
// Ports:
//  clk, rst            clock, synchronous active-high reset
//  hold_i              global freeze: every register holds
//  flush_i             kill the instruction entering EX
//  id_*                decoded instruction fields from ID
//  exmem_*, memwb_*    downstream writers, used for forwarding / hazard detection
//  stall_o             hold PC and IF/ID this cycle
//  ex_valid            EX slot holds a live instruction
//  alu_op/alu_a/alu_b  ALU controls and operands
//  ex_store_data       forwarded rt for stores
//  ex_rd, ex_reg_write, ex_mem_read, ex_mem_write  destination and gated control bits
module id_ex_stage
  import ex_pkg::*;
#(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hold_i,
  input  logic           flush_i,
  input  logic           id_valid,
  input  logic [3:0]     id_alu_op,
  input  logic [RAW-1:0] id_rs,
  input  logic [RAW-1:0] id_rt,
  input  logic [RAW-1:0] id_rd,
  input  logic [DW-1:0]  id_rs_data,
  input  logic [DW-1:0]  id_rt_data,
  input  logic [DW-1:0]  id_imm,
  input  logic [4:0]     id_shamt,
  input  logic           id_use_imm,
  input  logic           id_use_shamt,
  input  logic           id_use_rt,
  input  logic           id_reg_write,
  input  logic           id_mem_read,
  input  logic           id_mem_write,
  input  logic           exmem_reg_write,
  input  logic [RAW-1:0] exmem_rd,
  input  logic [DW-1:0]  exmem_result,
  input  logic           memwb_reg_write,
  input  logic [RAW-1:0] memwb_rd,
  input  logic [DW-1:0]  memwb_wdata,
  output logic           stall_o,
  output logic           ex_valid,
  output logic [3:0]     alu_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [DW-1:0]  ex_store_data,
  output logic [RAW-1:0] ex_rd,
  output logic           ex_reg_write,
  output logic           ex_mem_read,
  output logic           ex_mem_write
);

  logic           valid_q, valid_d;
  logic [3:0]     op_q, op_d;
  logic [RAW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DW-1:0]  rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [4:0]     shamt_q, shamt_d;
  logic           use_imm_q, use_imm_d, use_shamt_q, use_shamt_d;
  logic           reg_write_q, reg_write_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [DW-1:0]  fwd_rs, fwd_rt;
  logic           stall;

  // ID operand addresses against the EX destination (rt only if the instruction reads it).
  logic ex_match;
  assign ex_match = (rd_q != '0) &&
                    ((rd_q == id_rs) || (id_use_rt && (rd_q == id_rt)));

`ifdef EX_FORWARD_EN
  fwd_sel_t sel_rs, sel_rt;

  ex_fwd_unit #(.RAW(RAW)) u_fwd_rs (
    .src_i(rs_q), .exmem_reg_write_i(exmem_reg_write), .exmem_rd_i(exmem_rd),
    .memwb_reg_write_i(memwb_reg_write), .memwb_rd_i(memwb_rd), .sel_o(sel_rs)
  );

  ex_fwd_unit #(.RAW(RAW)) u_fwd_rt (
    .src_i(rt_q), .exmem_reg_write_i(exmem_reg_write), .exmem_rd_i(exmem_rd),
    .memwb_reg_write_i(memwb_reg_write), .memwb_rd_i(memwb_rd), .sel_o(sel_rt)
  );

  always_comb begin
    case (sel_rs)
      FWD_EXMEM: fwd_rs = exmem_result;
      FWD_MEMWB: fwd_rs = memwb_wdata;
      default:   fwd_rs = rs_data_q;
    endcase
    case (sel_rt)
      FWD_EXMEM: fwd_rt = exmem_result;
      FWD_MEMWB: fwd_rt = memwb_wdata;
      default:   fwd_rt = rt_data_q;
    endcase
  end

  // Only a load in EX cannot be bypassed: its data exists one stage too late.
  assign stall = id_valid && valid_q && mem_read_q && ex_match;
`else
  logic exmem_match;
  logic unused_fwd;

  assign fwd_rs = rs_data_q;
  assign fwd_rt = rt_data_q;

  assign exmem_match = exmem_reg_write && (exmem_rd != '0) &&
                       ((exmem_rd == id_rs) || (id_use_rt && (exmem_rd == id_rt)));

  // Without bypass every producer still in EX or EX/MEM must drain; MEM/WB is covered
  // by the regfile's write-before-read.
  assign stall = id_valid && ((valid_q && reg_write_q && ex_match) || exmem_match);

  assign unused_fwd = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_wdata, rs_q, rt_q};
`endif

  assign stall_o = stall;

  // Priority: hold > flush > load-use bubble > capture (reset handled in the register).
  always_comb begin
    valid_d     = valid_q;
    op_d        = op_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    shamt_d     = shamt_q;
    use_imm_d   = use_imm_q;
    use_shamt_d = use_shamt_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (hold_i) begin
      // everything keeps its value
    end else if (flush_i || stall) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else begin
      valid_d     = id_valid;
      op_d        = id_alu_op;
      rs_d        = id_rs;
      rt_d        = id_rt;
      rd_d        = id_rd;
      rs_data_d   = id_rs_data;
      rt_data_d   = id_rt_data;
      imm_d       = id_imm;
      shamt_d     = id_shamt;
      use_imm_d   = id_use_imm;
      use_shamt_d = id_use_shamt;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write;
    end
  end

  // ---- ID/EX register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      op_q        <= ALU_ADD;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      use_imm_q   <= 1'b0;
      use_shamt_q <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      op_q        <= op_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      shamt_q     <= shamt_d;
      use_imm_q   <= use_imm_d;
      use_shamt_q <= use_shamt_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign ex_valid      = valid_q;
  assign alu_op        = op_q;
  assign alu_a         = use_shamt_q ? {{(DW-5){1'b0}}, shamt_q} : fwd_rs;
  assign alu_b         = use_imm_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = valid_q & reg_write_q;
  assign ex_mem_read   = valid_q & mem_read_q;
  assign ex_mem_write  = valid_q & mem_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import ex_pkg::*;

  localparam int DW  = 32;
  localparam int RAW = 5;

  logic           clk = 1'b0;
  logic           rst, hold_i, flush_i;
  logic           id_valid;
  logic [3:0]     id_alu_op;
  logic [RAW-1:0] id_rs, id_rt, id_rd;
  logic [DW-1:0]  id_rs_data, id_rt_data, id_imm;
  logic [4:0]     id_shamt;
  logic           id_use_imm, id_use_shamt, id_use_rt;
  logic           id_reg_write, id_mem_read, id_mem_write;
  logic           exmem_reg_write;
  logic [RAW-1:0] exmem_rd;
  logic [DW-1:0]  exmem_result;
  logic           memwb_reg_write;
  logic [RAW-1:0] memwb_rd;
  logic [DW-1:0]  memwb_wdata;
  logic           stall_o, ex_valid;
  logic [3:0]     alu_op;
  logic [DW-1:0]  alu_a, alu_b, ex_store_data;
  logic [RAW-1:0] ex_rd;
  logic           ex_reg_write, ex_mem_read, ex_mem_write;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .RAW(RAW)) dut (
    .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid(id_valid), .id_alu_op(id_alu_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_use_imm(id_use_imm), .id_use_shamt(id_use_shamt), .id_use_rt(id_use_rt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
    .stall_o(stall_o), .ex_valid(ex_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_nop();
    id_valid = 0; id_alu_op = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
    id_use_imm = 0; id_use_shamt = 0; id_use_rt = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
  endtask

  task automatic id_set(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [4:0] sh, input logic ui,
                        input logic us, input logic ur, input logic rw, input logic mr,
                        input logic mw);
    id_valid = 1; id_alu_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh;
    id_use_imm = ui; id_use_shamt = us; id_use_rt = ur;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic down(input logic ewr, input logic [4:0] erd, input logic [31:0] eres,
                      input logic mwr, input logic [4:0] mrd, input logic [31:0] mwd);
    exmem_reg_write = ewr; exmem_rd = erd; exmem_result = eres;
    memwb_reg_write = mwr; memwb_rd = mrd; memwb_wdata = mwd;
  endtask

  task automatic expect_ex(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] sd, input logic [4:0] rd,
                           input logic rw, input logic mr, input logic mw);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.sd = sd; e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw;
    sb.push_back(e);
    sb_tag.push_back(tag);
  endtask

  task automatic pop_chk();
    exp_t  e;
    string t;
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL scoreboard_empty observed=0 entries expected=at least 1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      t = sb_tag.pop_front();
      chk({t, ".valid"}, 32'(ex_valid), 32'd1);
      chk({t, ".op"},    32'(alu_op), 32'(e.op));
      chk({t, ".a"},     alu_a, e.a);
      chk({t, ".b"},     alu_b, e.b);
      chk({t, ".sd"},    ex_store_data, e.sd);
      chk({t, ".rd"},    32'(ex_rd), 32'(e.rd));
      chk({t, ".rw"},    32'(ex_reg_write), 32'(e.rw));
      chk({t, ".mr"},    32'(ex_mem_read), 32'(e.mr));
      chk({t, ".mw"},    32'(ex_mem_write), 32'(e.mw));
    end
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'd0);
    chk({tag, ".rw"},    32'(ex_reg_write), 32'd0);
    chk({tag, ".mr"},    32'(ex_mem_read), 32'd0);
    chk({tag, ".mw"},    32'(ex_mem_write), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; hold_i = 0; flush_i = 0;
    id_nop();
    down(0, 0, 0, 0, 0, 0);
    tick(); tick();

    // reset state
    chk("rst.stall", 32'(stall_o), 0);
    chk("rst.alu_op", 32'(alu_op), 32'(ALU_ADD));
    chk("rst.alu_a", alu_a, 0);
    chk("rst.alu_b", alu_b, 0);
    chk("rst.sd", ex_store_data, 0);
    chk("rst.rd", 32'(ex_rd), 0);
    chk_bubble("rst");
    rst = 0;

    // case 1: ADD r3=r1+r2 then SUB r4=r3-r1
    id_set(ALU_ADD, 1, 2, 3, 5, 7, 0, 0, 0, 0, 1, 1, 0, 0);
    #1 chk("c1.add.stall", 32'(stall_o), 0);
    expect_ex("c1.add", ALU_ADD, 5, 7, 7, 3, 1, 0, 0);
    tick();
    id_set(ALU_SUB, 3, 1, 4, 32'h99, 5, 0, 0, 0, 0, 1, 1, 0, 0);
    #1 pop_chk();
`ifdef EX_FORWARD_EN
    chk("c1.sub.stall", 32'(stall_o), 0);
    expect_ex("c1.sub", ALU_SUB, 12, 5, 5, 4, 1, 0, 0);
    tick();
    id_nop();
    down(1, 3, 12, 0, 0, 0);
    #1 pop_chk();
`else
    chk("c1.stall_ex", 32'(stall_o), 1);
    tick();
    down(1, 3, 12, 0, 0, 0);
    #1 chk_bubble("c1.bub1");
    chk("c1.stall_exmem", 32'(stall_o), 1);
    tick();
    down(0, 0, 0, 1, 3, 12);
    id_rs_data = 12;
    #1 chk_bubble("c1.bub2");
    chk("c1.stall_clear", 32'(stall_o), 0);
    expect_ex("c1.sub", ALU_SUB, 12, 5, 5, 4, 1, 0, 0);
    tick();
    id_nop();
    down(0, 0, 0, 0, 0, 0);
    #1 pop_chk();
`endif
    down(0, 0, 0, 0, 0, 0);
    tick();

    // case 2: LW r5 then ADD r6=r5+r0
    id_set(ALU_ADD, 0, 0, 5, 0, 0, 32'h10, 0, 1, 0, 0, 1, 1, 0);
    #1 chk("c2.lw.stall", 32'(stall_o), 0);
    expect_ex("c2.lw", ALU_ADD, 0, 32'h10, 0, 5, 1, 1, 0);
    tick();
    id_set(ALU_ADD, 5, 0, 6, 32'h111, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    #1 pop_chk();
    chk("c2.stall1", 32'(stall_o), 1);
    tick();
    down(1, 5, 32'h10, 0, 0, 0);
    #1 chk_bubble("c2.bub");
`ifdef EX_FORWARD_EN
    chk("c2.stall2", 32'(stall_o), 0);
    expect_ex("c2.add", ALU_ADD, 32'hDEAD, 0, 0, 6, 1, 0, 0);
    tick();
    id_nop();
    down(0, 0, 0, 1, 5, 32'hDEAD);
    #1 pop_chk();
`else
    chk("c2.stall2", 32'(stall_o), 1);
    tick();
    down(0, 0, 0, 1, 5, 32'hDEAD);
    id_rs_data = 32'hDEAD;
    #1 chk_bubble("c2.bub2");
    chk("c2.stall3", 32'(stall_o), 0);
    expect_ex("c2.add", ALU_ADD, 32'hDEAD, 0, 0, 6, 1, 0, 0);
    tick();
    id_nop();
    down(0, 0, 0, 0, 0, 0);
    #1 pop_chk();
`endif
    down(0, 0, 0, 0, 0, 0);
    tick();

    // case 3: forwarding priority / reg 0 / hazard qualifiers
`ifdef EX_FORWARD_EN
    id_set(ALU_ADD, 7, 7, 9, 32'h77, 32'h77, 0, 0, 0, 0, 1, 1, 0, 0);
    #1 chk("c3.stall", 32'(stall_o), 0);
    expect_ex("c3.both", ALU_ADD, 32'hAA, 32'hAA, 32'hAA, 9, 1, 0, 0);
    tick();
    id_set(ALU_ADD, 0, 0, 10, 5, 6, 0, 0, 0, 0, 1, 1, 0, 0);
    down(1, 7, 32'hAA, 1, 7, 32'hBB);
    #1 pop_chk();
    expect_ex("c3.r0", ALU_ADD, 5, 6, 6, 10, 1, 0, 0);
    tick();
    id_set(ALU_OR, 7, 0, 11, 32'h77, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    down(1, 0, 32'hAA, 1, 0, 32'hBB);
    #1 pop_chk();
    expect_ex("c3.memwb", ALU_OR, 32'hBB, 0, 0, 11, 1, 0, 0);
    tick();
    id_nop();
    down(0, 7, 32'hAA, 1, 7, 32'hBB);
    #1 pop_chk();
`else
    id_set(ALU_ADD, 7, 8, 9, 32'h77, 32'h88, 0, 0, 0, 0, 1, 1, 0, 0);
    down(1, 0, 32'hAA, 1, 7, 32'hBB);
    #1 chk("c3.r0_nostall", 32'(stall_o), 0);
    expect_ex("c3.nobyp", ALU_ADD, 32'h77, 32'h88, 32'h88, 9, 1, 0, 0);
    tick();
    id_set(ALU_AND, 10, 9, 12, 32'h1010, 32'h2020, 32'h44, 0, 1, 0, 0, 1, 0, 0);
    down(1, 7, 32'hAA, 1, 7, 32'hBB);
    #1 pop_chk();
    chk("c3.no_use_rt", 32'(stall_o), 0);
    expect_ex("c3.imm", ALU_AND, 32'h1010, 32'h44, 32'h2020, 12, 1, 0, 0);
    tick();
    id_nop();
    down(0, 0, 0, 0, 0, 0);
    #1 pop_chk();
    id_set(ALU_ADD, 12, 0, 13, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    id_valid = 0;
    #1 chk("c3.novalid", 32'(stall_o), 0);
    tick();
    chk_bubble("c3.idle");
    id_valid = 1;
    down(0, 12, 0, 0, 0, 0);
    #1 chk("c3.exmem_norw", 32'(stall_o), 0);
    down(1, 12, 0, 0, 0, 0);
    #1 chk("c3.exmem_rw", 32'(stall_o), 1);
    id_nop();
`endif
    down(0, 0, 0, 0, 0, 0);

    // case 4: SLL r8,r9,4 with r9=1, then flush while a valid ADD sits in ID
    id_set(ALU_SLL, 0, 9, 8, 0, 1, 0, 4, 0, 1, 1, 1, 0, 0);
    #1 chk("c4.stall", 32'(stall_o), 0);
    expect_ex("c4.sll", ALU_SLL, 4, 1, 1, 8, 1, 0, 0);
    tick();
    id_set(ALU_ADD, 1, 2, 14, 3, 4, 0, 0, 0, 0, 1, 1, 0, 0);
    flush_i = 1;
    #1 pop_chk();
    tick();
    flush_i = 0;
    id_nop();
    #1 chk_bubble("c5.flush");

    // case 5: hold freezes EX for 3 cycles, even with flush and a hazard present
    id_set(ALU_XOR, 1, 2, 15, 32'h21, 32'h32, 0, 0, 0, 0, 1, 1, 0, 0);
    #1 chk("c5.cap.stall", 32'(stall_o), 0);
    expect_ex("c5.cap", ALU_XOR, 32'h21, 32'h32, 32'h32, 15, 1, 0, 0);
    tick();
    hold_i = 1;
    flush_i = 1;
    id_set(ALU_SUB, 15, 0, 16, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1 pop_chk();
    for (int k = 0; k < 3; k++) begin
`ifdef EX_FORWARD_EN
      chk($sformatf("c5.hold%0d.stall", k), 32'(stall_o), 0);
`else
      chk($sformatf("c5.hold%0d.stall", k), 32'(stall_o), 1);
`endif
      expect_ex($sformatf("c5.hold%0d", k), ALU_XOR, 32'h21, 32'h32, 32'h32, 15, 1, 0, 0);
      tick();
      pop_chk();
    end
    hold_i = 0;
    tick();
    flush_i = 0;
    id_nop();
    #1 chk_bubble("c5.post");

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
